// File: rtl/down_timer_pkg.sv
// Shared types and defaults for the down_timer block: FSM state encoding and counter width.
package down_timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage : down_timer_pkg

// File: rtl/down_timer.sv
// Loadable down-counter: a load of L gives a done pulse L+1 cycles later with optional auto-reload.
// Loads are accepted only in IDLE (load_ready); all outputs are registered Moore outputs.
module down_timer
    import down_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             abort,
    input  logic             reload,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_val,
    output logic             load_ready,
    output logic [WIDTH-1:0] cnt,
    output logic             busy,
    output logic             done
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] cnt_nxt;
    logic [WIDTH-1:0] rld, rld_nxt;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        rld_nxt   = rld;
        case (state)
            IDLE: begin
                if (load_valid) begin
                    rld_nxt   = load_val;
                    cnt_nxt   = load_val;
                    state_nxt = (load_val != '0) ? RUN : DONE;
                end
            end
            RUN: begin
                // cnt is never zero in RUN, so the <=1 test also guards against wrap
                if (en) begin
                    if (cnt <= WIDTH'(1)) begin
                        cnt_nxt   = '0;
                        state_nxt = DONE;
                    end else begin
                        cnt_nxt = cnt - WIDTH'(1);
                    end
                end
            end
            DONE: begin
                if (reload && (rld != '0)) begin
                    cnt_nxt   = rld;
                    state_nxt = RUN;
                end else begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
        if (abort) begin
            cnt_nxt   = '0;
            state_nxt = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            rld        <= '0;
            load_ready <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            rld        <= rld_nxt;
            load_ready <= (state_nxt == IDLE);
            busy       <= (state_nxt == RUN);
            done       <= (state_nxt == DONE);
        end
    end

`ifdef ASSERTS_SV
    a_run_nonzero : assert property (@(posedge clk) disable iff (rst)
        (state == RUN) |-> (cnt != '0));

    a_no_wrap : assert property (@(posedge clk) disable iff (rst)
        (state == RUN && en && !abort) |=> (cnt < $past(cnt)));

    a_done_one_cycle : assert property (@(posedge clk) disable iff (rst)
        done |=> !done);

    a_cnt_known : assert property (@(posedge clk) disable iff (rst)
        !$isunknown(cnt));

    a_hold_when_idle_en : assert property (@(posedge clk) disable iff (rst)
        (state == RUN && !en && !abort) |=> (state == RUN && cnt == $past(cnt)));
`endif

endmodule : down_timer

// File: tb/tb_down_timer.sv
// Directed and random stimulus for down_timer, checked every cycle against a behavioural model.
module tb_down_timer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst, en, abort, reload, load_valid;
    logic [W-1:0] load_val;
    logic         load_ready, busy, done;
    logic [W-1:0] cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Behavioural model: phase 0 = waiting for a load, 1 = counting, 2 = expiry cycle
    int m_phase = 0;
    int m_cnt   = 0;
    int m_rld   = 0;

    down_timer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .abort      (abort),
        .reload     (reload),
        .load_valid (load_valid),
        .load_val   (load_val),
        .load_ready (load_ready),
        .cnt        (cnt),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_update();
        if (rst) begin
            m_phase = 0; m_cnt = 0; m_rld = 0;
        end else if (abort) begin
            m_phase = 0; m_cnt = 0;
        end else if (m_phase == 0) begin
            if (load_valid) begin
                m_rld   = int'(load_val);
                m_cnt   = int'(load_val);
                m_phase = (m_cnt > 0) ? 1 : 2;
            end
        end else if (m_phase == 1) begin
            if (en) begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) m_phase = 2;
            end
        end else begin
            if (reload && m_rld > 0) begin
                m_cnt = m_rld; m_phase = 1;
            end else begin
                m_cnt = 0; m_phase = 0;
            end
        end
    endtask

    // Apply current inputs for one edge, then compare all outputs to the model.
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        cyc++;
        chk("cnt", 32'(cnt), 32'(m_cnt));
        chk("busy", 32'(busy), 32'(m_phase == 1));
        chk("done", 32'(done), 32'(m_phase == 2));
        chk("load_ready", 32'(load_ready), 32'(m_phase == 0));
    endtask

    task automatic do_load(input int v);
        load_valid = 1'b1;
        load_val   = W'(v);
        step();
        load_valid = 1'b0;
    endtask

    initial begin
        int last_done;
        int n;

        rst = 1'b1; en = 1'b0; abort = 1'b0; reload = 1'b0;
        load_valid = 1'b0; load_val = '0;
        step();
        chk("reset_cnt", 32'(cnt), 0);
        chk("reset_ready", 32'(load_ready), 1);
        rst = 1'b0;
        step();

        // Load 5 with enable held: 5,4,3,2,1,0, done, idle
        en = 1'b1;
        do_load(5);
        chk("l5_first", 32'(cnt), 5);
        repeat (7) step();
        chk("l5_idle_ready", 32'(load_ready), 1);

        // Load 3 with enable toggling
        do_load(3);
        en = 1'b0; step();
        en = 1'b1; step();
        en = 1'b0; step();
        chk("l3_held", 32'(cnt), 2);
        en = 1'b1; step();
        chk("l3_after3", 32'(done), 0);
        step();
        chk("l3_done", 32'(done), 1);
        repeat (2) step();

        // Load 2 with auto-reload: done every 3 cycles
        reload    = 1'b1;
        last_done = -1;
        do_load(2);
        repeat (10) begin
            step();
            if (done) begin
                if (last_done >= 0) chk("reload_period", 32'(cyc - last_done), 3);
                last_done = cyc;
            end
        end
        reload = 1'b0;
        n = 0;
        while (n < 10 && !load_ready) begin step(); n++; end
        chk("reload_stop_idle", 32'(load_ready), 1);

        // Load 0: done immediately, then idle
        do_load(0);
        chk("l0_done", 32'(done), 1);
        chk("l0_cnt", 32'(cnt), 0);
        step();

        // Load 8, abort at cnt=4 with an ignored load during RUN
        do_load(8);
        n = 0;
        while (n < 20 && cnt != 4) begin step(); n++; end
        chk("abort_at4", 32'(cnt), 4);
        load_valid = 1'b1; load_val = 8'd77;
        step();
        chk("run_load_ignored", 32'(cnt), 3);
        load_valid = 1'b0;
        abort = 1'b1; step();
        chk("abort_cnt", 32'(cnt), 0);
        chk("abort_nodone", 32'(done), 0);
        abort = 1'b0; step();
        chk("abort_nodone2", 32'(done), 0);

        // Reset mid-run at 200, then full 255 count
        do_load(210);
        n = 0;
        while (n < 20 && cnt != 200) begin step(); n++; end
        chk("rst_at200", 32'(cnt), 200);
        rst = 1'b1; step();
        chk("rst_mid_done", 32'(done), 0);
        rst = 1'b0;
        do_load(255);
        n = 0;
        while (n < 300 && !done) begin step(); n++; end
        chk("l255_len", 32'(n), 255);
        step();

        // Random traffic
        repeat (600) begin
            rst        = ($urandom_range(0, 59) == 0);
            abort      = ($urandom_range(0, 24) == 0);
            en         = ($urandom_range(0, 3) != 0);
            reload     = ($urandom_range(0, 1) == 1);
            load_valid = ($urandom_range(0, 2) == 0);
            load_val   = ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 255))
                                                     : W'($urandom_range(0, 6));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_down_timer
